// File: rtl/ksa_multiword_seq.sv
// Multi-word add sequencer: streams a WIDTH*WORDS operand pair through an external
// WIDTH-bit Kogge-Stone adder one word per cycle, LSW first, and chains the carry.
module ksa_multiword_seq #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*WORDS-1:0]   in_a,
    input  logic [WIDTH*WORDS-1:0]   in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*WORDS-1:0]   out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout
);

    localparam int TOTAL = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TOTAL-1:0]   a_q;
    logic [TOTAL-1:0]   b_q;
    logic [TOTAL-1:0]   sum_q;
    logic               carry_q;
    logic               valid_q;
    logic               cout_q;
    logic               ovf_q;

    // NOTE: in_ready is gated by rst_n so it reads 0 for the whole reset, not just after the first edge.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[int'(idx_q)*WIDTH +: WIDTH];
            add_b   = b_q[int'(idx_q)*WIDTH +: WIDTH];
            add_cin = carry_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q)*WIDTH +: WIDTH] <= add_sum;
                    carry_q <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        // Overflow = carry into the sign bit XOR carry out of it.
                        cout_q  <= add_cout;
                        ovf_q   <= add_cout ^ (a_q[TOTAL-1] ^ b_q[TOTAL-1] ^ add_sum[WIDTH-1]);
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_multiword_seq.sv
// Directed bench for ksa_multiword_seq (WIDTH=16, WORDS=4) with a behavioural adder
// attached and a 64-bit reference sum computed in the bench.
module tb_ksa_multiword_seq;

    localparam int WIDTH = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Attached adder: combinational 16-bit add with carry.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    ksa_multiword_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full 65-bit add, signed overflow from operand/result signs.
    task automatic golden(input logic [63:0] a, input logic [63:0] b, input logic c,
                          output logic [63:0] s, output logic co, output logic ov);
        logic [64:0] full;
        full = {1'b0, a} + {1'b0, b} + {64'd0, c};
        s  = full[63:0];
        co = full[64];
        ov = (a[63] == b[63]) && (s[63] != a[63]);
    endtask

    // Called at a negedge with in_ready high; returns at the negedge after the accept edge.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic c);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_cin = ~c;
    endtask

    // Walks the four RUN cycles, recording add_cin per word, and checks the latency.
    task automatic run_words(input string tag, output logic [3:0] cins);
        for (int i = 0; i < WORDS; i++) begin
            cins[i] = add_cin;
            check({tag, "_busy_valid"}, {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end
        check({tag, "_latency_valid"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic finish_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic c);
        logic [63:0] s;
        logic co, ov;
        golden(a, b, c, s, co, ov);
        check({tag, "_sum"}, out_sum, s);
        check({tag, "_cout"}, {63'd0, out_cout}, {63'd0, co});
        check({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, ov});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_handshake_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_handshake_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic rand_op(input logic [63:0] a, input logic [63:0] b, input logic c);
        logic [63:0] s;
        logic co, ov;
        int n;
        golden(a, b, c, s, co, ov);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = c;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("rand_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("rand_result_timeout", 64'd0, 64'd1);
        check("rand_sum", out_sum, s);
        check("rand_cout", {63'd0, out_cout}, {63'd0, co});
        check("rand_ovf", {63'd0, out_ovf}, {63'd0, ov});
        n = int'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]  cins;
        logic [63:0] held;
        logic [63:0] ra;
        logic [63:0] rb;

        // 1: reset state, then release
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_add_a", {48'd0, add_a}, 64'd0);
        check("rst_add_b", {48'd0, add_b}, 64'd0);
        check("rst_add_cin", {63'd0, add_cin}, 64'd0);
        check("rst_out_sum", out_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        check("rel_stray_ready_valid", {63'd0, out_valid}, 64'd0);

        // 2: all-ones + 0 + cin wraps to zero with carry out
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        check("t2_in_ready_busy", {63'd0, in_ready}, 64'd0);
        run_words("t2", cins);
        finish_op("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        check("t2_sum_const", out_sum, 64'd0);

        // 3: carry ripples through three words
        start_op(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check("t3_word0_a", {48'd0, add_a}, 64'h0000_0000_0000_FFFF);
        check("t3_word0_b", {48'd0, add_b}, 64'd1);
        run_words("t3", cins);
        check("t3_cin_seq", {60'd0, cins}, 64'b1110);
        check("t3_sum_const", out_sum, 64'h0001_0000_0000_0000);
        finish_op("t3", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check("t3_idle_add_a", {48'd0, add_a}, 64'd0);

        // 4: signed overflow without carry out
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_words("t4", cins);
        check("t4_sum_const", out_sum, 64'h8000_0000_0000_0000);
        check("t4_ovf_const", {63'd0, out_ovf}, 64'd1);
        check("t4_cout_const", {63'd0, out_cout}, 64'd0);
        finish_op("t4", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);

        // 5: back-pressure in DONE while a second operand pair waits
        start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b0);
        run_words("t5", cins);
        held = out_sum;
        check("t5_sum_const", held, 64'h2345_789A_CDF0_2334);
        in_valid = 1'b1;
        in_a = 64'h8000_0000_0000_0000;
        in_b = 64'h8000_0000_0000_0000;
        in_cin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid", {63'd0, out_valid}, 64'd1);
            check("t5_hold_sum", out_sum, held);
            check("t5_hold_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_hs_valid", {63'd0, out_valid}, 64'd0);
        check("t5_hs_ready", {63'd0, in_ready}, 64'd1);
        start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        run_words("t5b", cins);
        check("t5b_sum_const", out_sum, 64'd1);
        finish_op("t5b", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);

        // 6: reset pulse at idx 2 aborts the operation
        start_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("t6_rst_ready", {63'd0, in_ready}, 64'd0);
        check("t6_rst_add_a", {48'd0, add_a}, 64'd0);
        check("t6_rst_sum", out_sum, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_no_valid", {63'd0, out_valid}, 64'd0);
        end
        check("t6_ready_after", {63'd0, in_ready}, 64'd1);
        start_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        run_words("t6", cins);
        finish_op("t6", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);

        // Random operations with random back-pressure
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 17 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            if (i % 23 == 0) rb = 64'h7FFF_FFFF_FFFF_FFFF;
            rand_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
